period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous square-wave input, counted in cycles of the system clock.
- Intended as the receive-side check for divided clocks made elsewhere in the design, for example a toggle divider with terminal count n gives a period of 2n.
- Reports one result per input period, with a single-cycle valid strobe.
- Flags a timeout when the input stops toggling.

---
 rtl/period_meter_pkg.sv | 25 ++
 rtl/sig_sync_edge.sv | 92 +++++++++
 rtl/period_meter.sv | 168 ++++++++++++++++
 tb/tb_period_meter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
// Shared types and constants for the period meter.
//   state_t       : measurement FSM states (IDLE, MEASURE, TIMEOUT)
//   FILT_LEN_DEF  : default run length of the optional glitch filter
//   cnt_max()     : all-ones value of a counter of the given width
// Optional feature macro used by the block: GLITCH_FILTER_EN.
// -----------------------------------------------------------------------------
package period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   localparam int FILT_LEN_DEF = 4;

   // Saturation value of a w-bit counter. A shift by 32 yields 0, so the
   // subtraction still gives all ones for a full 32-bit counter.
   function automatic int unsigned cnt_max(input int unsigned w);
      return (int'(1) << w) - 1;
   endfunction

endpackage : period_meter_pkg

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
// Brings an asynchronous level into the clock domain and reports its edges.
// Two-flop synchronizer, an optional run-length glitch filter, then a
// previous-sample flop used for edge detection.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   i_sig    in   asynchronous input level
//   o_level  out  synchronized (and optionally filtered) level
//   o_rise   out  one-cycle pulse on a 0->1 change of o_level
//   o_fall   out  one-cycle pulse on a 1->0 change of o_level
//
// Configuration macro: GLITCH_FILTER_EN. When defined, o_level changes only
// after FILT_LEN consecutive synchronized samples disagree with it; shorter
// pulses never reach the edge detector. When undefined, the synchronizer
// output is used directly.
// -----------------------------------------------------------------------------
module sig_sync_edge
   import period_meter_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_level;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source; blocking here would collapse the
   // synchronizer chain into a single stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_sig;
         r_sync2 <= r_sync1;
      end
   end

`ifdef GLITCH_FILTER_EN
   localparam int RUN_W = $clog2(FILT_LEN + 1);

   logic [RUN_W-1:0] r_run;
   logic             r_filt;

   // r_run counts consecutive samples that differ from the accepted level;
   // any agreeing sample restarts the count, so only a full run flips it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_run  <= '0;
         r_filt <= 1'b0;
      end else if (r_sync2 == r_filt) begin
         r_run <= '0;
      end else if (r_run == RUN_W'(FILT_LEN - 1)) begin
         r_filt <= r_sync2;
         r_run  <= '0;
      end else begin
         r_run <= r_run + 1'b1;
      end
   end

   assign w_level = r_filt;
`else
   localparam int unused_filt_len = FILT_LEN;

   assign w_level = r_sync2;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule : sig_sync_edge

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the period and high time of a slow asynchronous square wave in
// system-clock cycles. One result per input period with a one-cycle valid
// strobe; a sticky timeout flag when no rising edge arrives before the cycle
// counter saturates.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   enable      in   measurement enable; 0 returns the FSM to IDLE
//   sig_in      in   asynchronous signal to be measured
//   period_o    out  last measured period (CNT_W bits)
//   high_o      out  last measured high time (CNT_W bits)
//   meas_valid  out  one-cycle pulse when period_o/high_o update
//   timeout     out  sticky: counter saturated without a rising edge
//
// Configuration macro: GLITCH_FILTER_EN (input run-length filter inside
// sig_sync_edge, FILT_LEN samples).
// -----------------------------------------------------------------------------
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             meas_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic w_level;
   logic w_rise;
   logic w_fall;
   logic w_unused;

   sig_sync_edge #(
      .FILT_LEN (FILT_LEN)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .i_sig   (sig_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // The FSM works from edges only; the level is exported by the sub-module
   // for other users and intentionally left unused here.
   assign w_unused = w_level;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_high_cap;
   logic [CNT_W-1:0] w_high_cap_nxt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] w_period_nxt;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] w_high_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_high_cap <= '0;
         r_period   <= '0;
         r_high     <= '0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_high_cap <= w_high_cap_nxt;
         r_period   <= w_period_nxt;
         r_high     <= w_high_nxt;
         r_valid    <= w_valid_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // NOTE: every signal written here gets a hold/default value first, so no
   // path through the case statement can leave one unassigned (no latches).
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_high_cap_nxt = r_high_cap;
      w_period_nxt   = r_period;
      w_high_nxt     = r_high;
      w_valid_nxt    = 1'b0;
      w_timeout_nxt  = r_timeout;

      if (!enable) begin
         // Results are kept; only the measurement itself is abandoned.
         w_state_nxt   = IDLE;
         w_cnt_nxt     = '0;
         w_timeout_nxt = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_cnt_nxt = '0;
               // First rise only opens a measurement; nothing to report yet.
               if (w_rise) begin
                  w_state_nxt = MEASURE;
                  w_cnt_nxt   = CNT_ONE;
               end
            end

            MEASURE: begin
               if (w_fall) begin
                  w_high_cap_nxt = r_cnt;
               end
               // A rise in the saturation cycle is still a valid period, so
               // it is tested before the timeout condition.
               if (w_rise) begin
                  w_period_nxt = r_cnt;
                  w_high_nxt   = r_high_cap;
                  w_valid_nxt  = 1'b1;
                  w_cnt_nxt    = CNT_ONE;
               end else if (r_cnt == CNT_MAX) begin
                  w_state_nxt   = TIMEOUT;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end

            TIMEOUT: begin
               // Counter stays frozen; the partial period is dropped.
               if (w_rise) begin
                  w_state_nxt = MEASURE;
                  w_cnt_nxt   = CNT_ONE;
               end
            end

            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign period_o   = r_period;
   assign high_o     = r_high;
   assign meas_valid = r_valid;
   assign timeout    = r_timeout;

endmodule : period_meter

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
// Scoreboard bench for period_meter (CNT_W = 6 so saturation is reachable).
// Stimulus pushes the hand-computed result each completed period should give;
// a monitor pops on every meas_valid and compares period, high time and the
// spacing between strobes. Any strobe with an empty queue is an error.
// Honours GLITCH_FILTER_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_period_meter;

   localparam int CNT_W = 6;
   localparam int CNT_M = 63;

`ifdef GLITCH_FILTER_EN
   localparam int T2_HIGH = 5;
`else
   localparam int T2_HIGH = 3;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic             sig_in;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] high_o;
   logic             meas_valid;
   logic             timeout;

   always #5 clock = ~clock;

   period_meter #(
      .CNT_W    (CNT_W),
      .FILT_LEN (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .sig_in     (sig_in),
      .period_o   (period_o),
      .high_o     (high_o),
      .meas_valid (meas_valid),
      .timeout    (timeout)
   );

   typedef struct {
      int period;
      int high;
      int gap;    // expected clocks since previous strobe, 0 = not checked
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   last_valid_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (meas_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got period=%0d high=%0d, expected no strobe (t=%0t)",
                     period_o, high_o, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("period", 32'(period_o), e.period);
            check("high", 32'(high_o), e.high);
            if (e.gap > 0) check("valid_gap", cyc - last_valid_cyc, e.gap);
         end
         last_valid_cyc = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input int p, input int h, input int g);
      exp_t e;
      e.period = p;
      e.high   = h;
      e.gap    = g;
      sb_q.push_back(e);
   endtask

   // n periods of h high / l low. Starting from IDLE the first rise yields no
   // result, so expectations begin one period later.
   task automatic run_periods(input int h, input int l, input int n,
                              input bit from_idle);
      int first;
      first = from_idle ? 1 : 0;
      for (int i = 0; i < n; i++) begin
         if (i >= first) push(h + l, h, (i > first) ? (h + l) : 0);
         sig_in = 1'b1;
         tick(h);
         sig_in = 1'b0;
         tick(l);
      end
   endtask

   task automatic idle_cycle();
      enable = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(2);
   endtask

   initial begin
      int k;
      reset  = 1'b1;
      enable = 1'b0;
      sig_in = 1'b0;
      tick(2);
      check("rst_period", 32'(period_o), 0);
      check("rst_high", 32'(high_o), 0);
      check("rst_valid", 32'(meas_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(2);

      // 50% duty, toggling every 10 clocks.
      run_periods(10, 10, 6, 1'b1);
      check("t1_drain", sb_q.size(), 0);

      // Short high phase, period 12.
      idle_cycle();
      run_periods(T2_HIGH, 12 - T2_HIGH, 5, 1'b1);
      check("t2_drain", sb_q.size(), 0);

      // Period exactly at saturation: rise wins, no timeout.
      idle_cycle();
      sig_in = 1'b1;
      tick(20);
      sig_in = 1'b0;
      tick(CNT_M - 20);
      push(CNT_M, 20, 0);
      sig_in = 1'b1;
      k = 0;
      while (meas_valid !== 1'b1 && k < 30) begin
         tick(1);
         k++;
      end
      check("sat_valid_seen", 32'(meas_valid), 1);
      check("sat_no_timeout", 32'(timeout), 0);

      // Hold the input: timeout exactly CNT_M clocks after that rise.
      k = 0;
      while (timeout !== 1'b1 && k < 100) begin
         tick(1);
         k++;
         if (k == 20) sig_in = 1'b0;
      end
      check("timeout_latency", k, CNT_M);

      // Two rises resume results; the flag stays sticky.
      sig_in = 1'b1;
      tick(8);
      sig_in = 1'b0;
      tick(12);
      push(20, 8, 0);
      sig_in = 1'b1;
      tick(8);
      sig_in = 1'b0;
      tick(12);
      check("to_drain", sb_q.size(), 0);
      check("timeout_sticky", 32'(timeout), 1);
      enable = 1'b0;
      tick(1);
      check("timeout_cleared", 32'(timeout), 0);
      check("dis_hold_period", 32'(period_o), 20);

      // Enable dropped mid-measurement for 5 clocks.
      enable = 1'b1;
      tick(2);
      run_periods(6, 10, 3, 1'b1);
      enable = 1'b0;
      tick(5);
      check("en_hold_period", 32'(period_o), 16);
      check("en_hold_high", 32'(high_o), 6);
      enable = 1'b1;
      run_periods(7, 7, 3, 1'b1);
      check("en_drain", sb_q.size(), 0);

      // Asynchronous reset between clock edges, mid-period.
      idle_cycle();
      sig_in = 1'b1;
      tick(4);
      #2;
      reset  = 1'b1;
      sig_in = 1'b0;
      #1;
      check("arst_period", 32'(period_o), 0);
      check("arst_high", 32'(high_o), 0);
      check("arst_timeout", 32'(timeout), 0);
      #1;
      reset = 1'b0;
      tick(5);
      check("arst_period_after", 32'(period_o), 0);
      run_periods(10, 10, 3, 1'b1);
      check("arst_drain", sb_q.size(), 0);

`ifdef GLITCH_FILTER_EN
      // 40-clock period, 20 high, 2-clock glitch in the low phase.
      idle_cycle();
      for (int i = 0; i < 4; i++) begin
         if (i >= 1) push(40, 20, (i > 1) ? 40 : 0);
         sig_in = 1'b1;
         tick(20);
         sig_in = 1'b0;
         tick(9);
         sig_in = 1'b1;
         tick(2);
         sig_in = 1'b0;
         tick(9);
      end
      check("glitch_drain", sb_q.size(), 0);
`endif

      tick(4);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_period_meter
